// File: rtl/register_file_param.sv
// Parametrised GPR file: byte-enabled write port, NREAD combinational read ports with
// same-cycle write bypass, optional hardwired zero register and a post-reset clear sweep.
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rstd,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       wbe,
    output logic                      busy
);

    localparam int NBYTE = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [ADDR_W-1:0]   clrCnt;
    logic                clrLast;
    logic                sweepWr;
    logic                zeroDrop;
    logic                wrEn;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [DATA_W-1:0] mergeBytes(
        input logic [DATA_W-1:0] oldWord,
        input logic [DATA_W-1:0] newWord,
        input logic [NBYTE-1:0]  be
    );
        logic [DATA_W-1:0] merged;
        merged = oldWord;
        for (int b = 0; b < NBYTE; b++) begin
            if (be[b]) merged[8*b +: 8] = newWord[8*b +: 8];
        end
        return merged;
    endfunction

    // Terminal-count compare: the counter wraps to 0 on the last edge, but the FSM has
    // already left CLEAR, so no second sweep can start.
    assign clrLast  = (clrCnt == ADDR_W'(DEPTH - 1));
    assign busy     = (state == CLEAR);
    assign sweepWr  = busy && rstd;
    assign zeroDrop = (ZERO_REG != 0) && (waddr == '0);
    assign wrEn     = (state == RUN) && we && !zeroDrop;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state  <= CLEAR;
            clrCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == CLEAR) clrCnt <= clrCnt + ADDR_W'(1);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            CLEAR:   if (clrLast) stateNext = RUN;
            RUN:     stateNext = RUN;
            default: stateNext = CLEAR;
        endcase
    end

    // Storage has no reset; the sweep zeroes it one entry per cycle. Gating on rstd keeps
    // the edge that coincides with an asserted reset from touching the array.
    always_ff @(posedge clk) begin
        if (sweepWr) begin
            mem[clrCnt] <= '0;
        end else if (wrEn) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : gRead
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] portData;

        assign ra     = raddr[k*ADDR_W +: ADDR_W];
        assign stored = mem[ra];

        always_comb begin
            portData = stored;
            if (state != RUN) begin
                portData = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                portData = '0;
            end else if (wrEn && (waddr == ra)) begin
                portData = mergeBytes(stored, wdata, wbe);
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = portData;
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default build, ZERO_REG=0 build and a
// 64-bit / 8-entry / 4-port build, all sharing clock and reset.
module tb_register_file_param;

    logic         clk = 1'b0;
    logic         rstd;

    // Default build (32x32, 2 ports, zero register)
    logic [9:0]   raddr0;
    logic [63:0]  rdata0;
    logic         we0;
    logic [4:0]   waddr0;
    logic [31:0]  wdata0;
    logic [3:0]   wbe0;
    logic         busy0;

    // ZERO_REG = 0 build
    logic [9:0]   raddr1;
    logic [63:0]  rdata1;
    logic         we1;
    logic [4:0]   waddr1;
    logic [31:0]  wdata1;
    logic [3:0]   wbe1;
    logic         busy1;

    // 64-bit, 8-entry, 4-port build
    logic [11:0]  raddr2;
    logic [255:0] rdata2;
    logic         we2;
    logic [2:0]   waddr2;
    logic [63:0]  wdata2;
    logic [7:0]   wbe2;
    logic         busy2;

    int tests = 0;
    int fails = 0;
    int d0, d1, d2, cnt;

    register_file_param #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut0 (
        .clk(clk), .rstd(rstd), .raddr(raddr0), .rdata(rdata0), .we(we0),
        .waddr(waddr0), .wdata(wdata0), .wbe(wbe0), .busy(busy0)
    );

    register_file_param #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) dut1 (
        .clk(clk), .rstd(rstd), .raddr(raddr1), .rdata(rdata1), .we(we1),
        .waddr(waddr1), .wdata(wdata1), .wbe(wbe1), .busy(busy1)
    );

    register_file_param #(.DATA_W(64), .ADDR_W(3), .NREAD(4), .ZERO_REG(1)) dut2 (
        .clk(clk), .rstd(rstd), .raddr(raddr2), .rdata(rdata2), .we(we2),
        .waddr(waddr2), .wdata(wdata2), .wbe(wbe2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstd = 1'b1;
        raddr0 = '0; we0 = 1'b0; waddr0 = '0; wdata0 = '0; wbe0 = '0;
        raddr1 = '0; we1 = 1'b0; waddr1 = '0; wdata1 = '0; wbe1 = '0;
        raddr2 = '0; we2 = 1'b0; waddr2 = '0; wdata2 = '0; wbe2 = '0;

        // Reset state
        #2 rstd = 1'b0;
        #1;
        chk("rst_busy0", 64'(busy0), 64'd1);
        chk("rst_busy2", 64'(busy2), 64'd1);
        chk("rst_rdata0", rdata0, 64'd0);
        repeat (3) step();
        chk("rst_hold_busy0", 64'(busy0), 64'd1);

        // Sweep length: count posedges after release until busy drops
        rstd = 1'b1;
        d0 = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (!busy0 && d0 == 0) d0 = c;
            if (!busy1 && d1 == 0) d1 = c;
            if (!busy2 && d2 == 0) d2 = c;
            if (d0 != 0 && d1 != 0 && d2 != 0) break;
        end
        chk("sweep_len0", 64'(d0), 64'd32);
        chk("sweep_len1", 64'(d1), 64'd32);
        chk("sweep_len2", 64'(d2), 64'd8);

        // Every entry cleared, seen on both ports
        for (int i = 0; i < 32; i++) begin
            raddr0 = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("cleared_r%0d", i), rdata0, 64'd0);
        end

        // Full write then partial byte write
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; wbe0 = 4'hF;
        step();
        we0 = 1'b0; raddr0 = {5'd0, 5'd5};
        #1;
        chk("wr_full_r5", 64'(rdata0[31:0]), 64'hDEADBEEF);
        we0 = 1'b1; wdata0 = 32'h000000AA; wbe0 = 4'h1;
        step();
        we0 = 1'b0;
        #1;
        chk("wr_byte_r5", 64'(rdata0[31:0]), 64'hDEADBEAA);

        // we with no byte enables changes nothing
        we0 = 1'b1; wdata0 = 32'h0; wbe0 = 4'h0;
        step();
        we0 = 1'b0;
        #1;
        chk("wr_nobe_r5", 64'(rdata0[31:0]), 64'hDEADBEAA);

        // Bypass with partial byte enables
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111; wbe0 = 4'hF;
        step();
        wdata0 = 32'h22222222; wbe0 = 4'hC; raddr0 = {5'd7, 5'd5};
        #1;
        chk("bypass_port1", 64'(rdata0[63:32]), 64'h22221111);
        chk("bypass_port0_other", 64'(rdata0[31:0]), 64'hDEADBEAA);
        step();
        we0 = 1'b0;
        #1;
        chk("bypass_persist", 64'(rdata0[63:32]), 64'h22221111);

        // Zero register: dropped with ZERO_REG=1, stored with ZERO_REG=0
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; wbe0 = 4'hF; raddr0 = '0;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; wbe1 = 4'hF; raddr1 = '0;
        #1;
        chk("zero_same_cycle", rdata0, 64'd0);
        step();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("zero_after", rdata0, 64'd0);
        chk("nozero_r0", rdata1, 64'hFFFFFFFF_FFFFFFFF);

        // Wide build: four independent ports
        we2 = 1'b1; waddr2 = 3'd1; wdata2 = 64'h0123456789ABCDEF; wbe2 = 8'hFF;
        step();
        waddr2 = 3'd2; wdata2 = 64'h00000000000000F0; wbe2 = 8'h01;
        step();
        we2 = 1'b0; raddr2 = {3'd0, 3'd2, 3'd1, 3'd1};
        #1;
        chk("wide_p0_r1", rdata2[63:0], 64'h0123456789ABCDEF);
        chk("wide_p1_r1", rdata2[127:64], 64'h0123456789ABCDEF);
        chk("wide_p2_r2", rdata2[191:128], 64'h00000000000000F0);
        chk("wide_p3_r0", rdata2[255:192], 64'd0);

        // Reset mid-operation is immediate; writes during reset are lost
        raddr0 = {5'd5, 5'd5};
        rstd = 1'b0;
        #1;
        chk("midop_busy", 64'(busy0), 64'd1);
        chk("midop_rdata", rdata0, 64'd0);
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678; wbe0 = 4'hF;
        step();
        step();
        rstd = 1'b1;
        repeat (10) step();
        chk("sweep10_busy", 64'(busy0), 64'd1);
        rstd = 1'b0;
        #1;
        chk("midsweep_busy", 64'(busy0), 64'd1);
        step();
        rstd = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (!busy0) begin
                cnt = c;
                break;
            end
        end
        we0 = 1'b0;
        chk("restart_len", 64'(cnt), 64'd32);
        raddr0 = {5'd5, 5'd9};
        #1;
        chk("busy_write_dropped_r9", 64'(rdata0[31:0]), 64'd0);
        chk("reswept_r5", 64'(rdata0[63:32]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
